// File: rtl/memory_bridge.sv
// Single-request bridge from the core memory port to a synchronous word SRAM.
// Partial-mask writes become read-modify-write; out-of-window requests raise bus_error.
module memory_bridge #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memory_enable,
  input  logic                  memory_command,
  input  logic [31:0]           read_memory_address,
  input  logic [31:0]           write_memory_address,
  input  logic [31:0]           write_memory_data,
  input  logic [31:0]           write_memory_mask,
  output logic                  memory_ready,
  output logic                  memory_valid,
  output logic [31:0]           read_memory_data,
  output logic                  bus_error,
  output logic                  sram_enable,
  output logic                  sram_write,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [31:0]           sram_write_data,
  input  logic [31:0]           sram_read_data
);

  localparam logic [32:0] WindowBytes = 33'(4) << ADDR_WIDTH;
  localparam logic [1:0]  LastWait    = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StRmwIssue,
    StRmwWait,
    StWr
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           mask_q, mask_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic [31:0]           req_addr;
  logic [31:0]           offset;
  logic                  in_window;

  // 33-bit compare so the window test also works when the window spans the whole address space.
  always_comb begin
    req_addr  = memory_command ? write_memory_address : read_memory_address;
    offset    = req_addr - BASE_ADDRESS;
    in_window = {1'b0, offset} < WindowBytes;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (memory_enable) begin
          if (!in_window) begin
            error_d = 1'b1;
            if (!memory_command) begin
              valid_d = 1'b1;
              rdata_d = '0;
            end
          end else if (!memory_command) begin
            state_d = StRdIssue;
            addr_d  = offset[ADDR_WIDTH+1:2];
          end else if (write_memory_mask == '1) begin
            state_d = StWr;
            addr_d  = offset[ADDR_WIDTH+1:2];
            wdata_d = write_memory_data;
          end else if (write_memory_mask != '0) begin
            state_d = StRmwIssue;
            addr_d  = offset[ADDR_WIDTH+1:2];
            data_d  = write_memory_data;
            mask_d  = write_memory_mask;
          end
        end
      end
      StRdIssue: begin
        state_d = StRdWait;
        wait_d  = '0;
      end
      StRdWait: begin
        if (wait_q == LastWait) begin
          rdata_d = sram_read_data;
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StRmwIssue: begin
        state_d = StRmwWait;
        wait_d  = '0;
      end
      StRmwWait: begin
        if (wait_q == LastWait) begin
          wdata_d = (sram_read_data & ~mask_q) | (data_q & mask_q);
          state_d = StWr;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StWr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign memory_ready     = (state_q == StIdle) && !reset;
  assign memory_valid     = valid_q;
  assign read_memory_data = rdata_q;
  assign bus_error        = error_q;
  assign sram_enable      = (state_q == StRdIssue) || (state_q == StRmwIssue) || (state_q == StWr);
  assign sram_write       = (state_q == StWr);
  assign sram_address     = addr_q;
  assign sram_write_data  = wdata_q;

endmodule
